// File: rtl/piso_sipo_pkg.sv
// Shared definitions for the PISO transmitter / SIPO receiver pair.
//   DEFAULT_DATA_WIDTH : default frame/word width in bits
//   bit_cntr_width()   : width of the per-frame bit counter for a given word width
package piso_sipo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // One extra bit over $clog2 so the counter range never wraps for any legal width
  function automatic int bit_cntr_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-deep valid/ready holding register for assembled SIPO words.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : a completed word is offered this cycle
//   wr_data     : the completed word
//   ready_in    : downstream accepts when valid_out && ready_in
//   data_out    : held word
//   valid_out   : holding register contains an unconsumed word
//   drop        : one-cycle pulse, the offered word was discarded (register full, not accepted)
module sipo_hold_reg
  import piso_sipo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  drop
);

  logic accept;
  logic can_write;

  assign accept    = valid_out && ready_in;
  // A full register frees its slot on the same edge it is accepted, so a new
  // word may land there without a bubble.
  assign can_write = !valid_out || ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      drop      <= 1'b0;
    end else begin
      drop <= wr_en && !can_write;
      if (wr_en && can_write) begin
        data_out  <= wr_data;
        valid_out <= 1'b1;
      end else if (accept) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo.sv
// Serial-in parallel-out receiver, LSB first, counterpart of the PISO transmitter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sdata_in   : serial data line, LSB first
//   svalid_in  : high for DATA_WIDTH consecutive cycles per frame
//   data_out   : assembled word from the holding register
//   valid_out  : holding register holds an unconsumed word
//   ready_in   : downstream accept (valid_out && ready_in)
//   busy       : a frame is partially received
//   frame_err  : one-cycle pulse, frame truncated by svalid_in dropping early
//   overrun    : one-cycle pulse, completed word dropped under backpressure
module sipo
  import piso_sipo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sdata_in,
  input  logic                  svalid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int             CW   = bit_cntr_width(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] word;
  logic                  complete;
  logic                  truncate;

  // Incoming bit enters at the MSB so that after DATA_WIDTH shifts the first
  // (LSB-first) bit sits at bit 0.
  assign word     = {sdata_in, shreg[DATA_WIDTH-1:1]};
  assign complete = svalid_in && (cnt == LAST);
  assign truncate = !svalid_in && (cnt != '0);
  assign busy     = (cnt != '0);

  // Capture stage: shift register, bit counter, truncation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= truncate;
      if (svalid_in) begin
        shreg <= word;
        cnt   <= complete ? '0 : cnt + CW'(1);
      end else if (truncate) begin
        cnt <= '0;
      end
    end
  end

  // Output stage: completed word offered to the holding register
  sipo_hold_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (complete),
    .wr_data   (word),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .drop      (overrun)
  );

endmodule

// File: doc/sipo.md
Name: sipo

Overview:
- Serial-In-Parallel-Out receiver; the receive-side counterpart of the team's PISO transmitter.
- Samples a 1-bit data line, LSB first, while a serial valid is high, and assembles DATA_WIDTH-bit words.
- Presents each word on a parallel valid/ready interface through a one-deep holding register.
- Flags truncated frames and words dropped under backpressure.

Parameters:
- DATA_WIDTH, 8, bits per frame/word; legal range >= 2.

Ports:
- clk  input  1  clock; all state on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- sdata_in  input  1  serial data line, LSB first.
- svalid_in  input  1  high for exactly DATA_WIDTH consecutive cycles per frame.
- data_out  output  DATA_WIDTH  assembled word from the holding register.
- valid_out  output  1  holding register contains an unconsumed word.
- ready_in  input  1  downstream accepts the word when valid_out && ready_in.
- busy  output  1  a frame is partially received.
- frame_err  output  1  one-cycle pulse when a frame is truncated.
- overrun  output  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset (async, rst_n=0):
  - shift register, bit counter, data_out, valid_out, busy, frame_err and overrun all go to 0.
  - Any partial frame is discarded.
  - Reset has no effect on outputs beyond clearing them.
- Bit counter:
  - width $clog2(DATA_WIDTH)+1; counts 0..DATA_WIDTH-1.
  - busy = (cnt != 0), registered-state derived.
- Capture, on each edge with svalid_in=1:
  - shreg <= {sdata_in, shreg[DATA_WIDTH-1:1]}.
  - cnt <= cnt+1.
- Completion: an edge with svalid_in=1 and cnt==DATA_WIDTH-1.
  - word = {sdata_in, shreg[DATA_WIDTH-1:1]}.
  - cnt <= 0, so busy is low the next cycle.
  - Back-to-back frames are supported: svalid_in may stay high and the next edge starts a new frame with no idle cycle.
- Holding register write rule, at the completion edge:
  - empty (valid_out=0): data_out <= word, valid_out <= 1.
  - full and accepted this cycle (valid_out && ready_in): data_out <= word, valid_out stays 1, no overrun.
  - full and not accepted: word dropped, data_out/valid_out unchanged, overrun=1 for the next cycle only.
- Accept without completion: valid_out && ready_in clears valid_out next cycle. data_out holds its last value; it is don't-care when valid_out=0.
- Latency: valid_out rises 1 cycle after the edge that samples the final bit.
- Truncation, an edge with svalid_in=0 and cnt!=0:
  - cnt <= 0.
  - frame_err=1 for the next cycle only.
  - Partial bits discarded; holding register unaffected.
- Idle: svalid_in=0 and cnt==0 leaves state unchanged. sdata_in is ignored whenever svalid_in=0.
- frame_err and overrun are registered single-cycle pulses. They are never asserted together from the same edge.
- Protocol compatibility: directly consumes PISO output (data_out -> sdata_in, valid_out -> svalid_in) with identical DATA_WIDTH.

Decomposition:
- Shared package piso_sipo_pkg holds:
  - DEFAULT_DATA_WIDTH = 8.
  - function bit_cntr_width(w) = $clog2(w)+1, used by both PISO and sipo.
- One natural sub-module, sipo_hold_reg: the one-deep valid/ready holding register.
  - inputs: wr_en, wr_data, ready_in.
  - outputs: data_out, valid_out, drop (which drives overrun).
- Shift register, counter and error logic live in sipo.

Test Plan:
1. Single frame 0xA5 (bits 1,0,1,0,0,1,0,1), ready_in=1 -> valid_out high exactly 1 cycle after the 8th bit with data_out=0xA5; valid_out low next cycle; busy high for 7 cycles; no pulses.
2. Loopback from PISO: send 0x96, then 0x3C as soon as PISO busy drops; also drive 16 contiguous svalid cycles carrying 0xC3,0x0F -> words received in order (0x96,0x3C,0xC3,0x0F); frame_err/overrun never assert.
3. Truncation: 5 valid bits then svalid_in=0 -> frame_err pulse 1 cycle, busy low, no valid_out; following full frame 0xFF -> data_out=0xFF.
4. Backpressure: ready_in=0, frames 0x11 then 0x22 -> valid_out held with 0x11, overrun pulse 1 cycle after 0x22 completes; raise ready_in -> 0x11 accepted, valid_out low.
5. Simultaneous: holding 0x11 full, ready_in=1 on the same edge 0x44 completes -> valid_out stays 1, data_out=0x44, no overrun.
6. Reset mid-frame after 4 bits -> all outputs 0 immediately (async); after release, full frame 0x5A -> data_out=0x5A with no residue from the partial frame.
